// File: rtl/dbus_mem_responder_pkg.sv
// Shared types for the data-bus memory responder: request/response structs, size codes, FSM states.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package dbus_mem_responder_pkg;

  // Access size codes carried in dbus_req_t.size
  localparam logic [1:0] MSIZE1 = 2'd0;
  localparam logic [1:0] MSIZE2 = 2'd1;
  localparam logic [1:0] MSIZE4 = 2'd2;
  localparam logic [1:0] MSIZE8 = 2'd3;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [1:0]  size;
    logic [7:0]  strobe;   // all-zero strobe means read
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_WAIT = 2'd1,
    RSP_RESP = 2'd2
  } rsp_state_t;

  // True when the low address bits are not a multiple of the access size.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
    logic r;
    case (size)
      MSIZE2:  r = a[0];
      MSIZE4:  r = |a[1:0];
      MSIZE8:  r = |a;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dbus_mem_responder_byte_strobe_ram.sv
// DEPTH x 64-bit storage with per-byte write enables (byte_strobe_ram).
// Latency: write lands at the clock edge; read is combinational from raddr_i.
// Backpressure: none, accepts a write every cycle.
// Ports: clk_i clock; we_i/be_i/waddr_i/wdata_i write port; raddr_i/rdata_o async read port.
module byte_strobe_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [7:0]    be_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [63:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [63:0]   rdata_o
);

  // No reset: contents survive responder resets.
  logic [63:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 8; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dbus_mem_responder.sv
// Single-outstanding data-bus memory responder with byte-strobe writes and a backdoor load port.
// Latency: data_ok LATENCY+1 cycles after the addr_ok cycle; RESP lasts one cycle.
// Backpressure: addr_ok only in IDLE, so a second request waits until the previous response ends.
// Ports: clk; reset (async, active-low); dreq/dresp bus pair; bus_err pulse with data_ok;
//        init_we/init_idx/init_data backdoor word write, honoured only in IDLE.
module dbus_mem_responder
  import dbus_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 2,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  dbus_req_t     dreq,
  output dbus_resp_t    dresp,
  output logic          bus_err,
  input  logic          init_we,
  input  logic [AW-1:0] init_idx,
  input  logic [63:0]   init_data
);

  rsp_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [7:0]  strobe_q, strobe_d;
  logic [63:0] data_q, data_d;

  logic [63:0] off;
  logic        err;
  logic [AW-1:0] idx;
  logic        ram_we;
  logic [7:0]  ram_be;
  logic [AW-1:0] ram_waddr;
  logic [63:0] ram_wdata;
  logic [63:0] ram_rdata;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    size_d   = size_q;
    strobe_d = strobe_q;
    data_d   = data_q;
    case (state_q)
      RSP_IDLE: begin
        if (dreq.valid) begin
          addr_d   = dreq.addr;
          size_d   = dreq.size;
          strobe_d = dreq.strobe;
          data_d   = dreq.data;
          if (LATENCY == 0) begin
            state_d = RSP_RESP;
          end else begin
            state_d = RSP_WAIT;
            cnt_d   = 4'(LATENCY);
          end
        end
      end
      RSP_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RSP_RESP;
      end
      RSP_RESP: state_d = RSP_IDLE;
      default:  state_d = RSP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RSP_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 64'd0;
      size_q   <= 2'd0;
      strobe_q <= 8'd0;
      data_q   <= 64'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
    end
  end

  // Decode the latched request. Only consumed in RESP, so the stale value in IDLE is harmless.
  assign off = addr_q - BASE;
  assign err = (addr_q < BASE) || ((off >> 3) >= 64'(DEPTH)) || misaligned(size_q, addr_q[2:0]);
  assign idx = off[AW+2:3];

  // One write port shared by the backdoor (IDLE) and bus writes (RESP edge); the two never overlap.
  always_comb begin
    ram_we    = 1'b0;
    ram_be    = strobe_q;
    ram_waddr = idx;
    ram_wdata = data_q;
    if (state_q == RSP_IDLE) begin
      ram_we    = init_we;
      ram_be    = 8'hFF;
      ram_waddr = init_idx;
      ram_wdata = init_data;
    end else if (state_q == RSP_RESP) begin
      ram_we    = (|strobe_q) && !err;
    end
  end

  byte_strobe_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (idx),
    .rdata_o (ram_rdata)
  );

  // Read data in RESP is the pre-write word because the write lands on the RESP edge.
  assign dresp.addr_ok = (state_q == RSP_IDLE) && dreq.valid;
  assign dresp.data_ok = (state_q == RSP_RESP);
  assign dresp.data    = ((state_q == RSP_RESP) && !err) ? ram_rdata : 64'd0;
  assign bus_err       = (state_q == RSP_RESP) && err;

endmodule

// File: tb/tb_dbus_mem_responder.sv
module tb_dbus_mem_responder;
  import dbus_mem_responder_pkg::*;

  logic       clk;
  logic       reset;
  dbus_req_t  dreq;
  logic       init_we;
  logic [8:0] init_idx;
  logic [63:0] init_data;
  bit         sel;          // 0: LATENCY=2 instance, 1: LATENCY=0 instance

  dbus_req_t  dreq_a, dreq_b;
  dbus_resp_t resp_a, resp_b, resp;
  logic       berr_a, berr_b, berr;
  logic       iwe_a, iwe_b;

  int checks = 0;
  int errors = 0;

  assign dreq_a = sel ? '0 : dreq;
  assign dreq_b = sel ? dreq : '0;
  assign iwe_a  = sel ? 1'b0 : init_we;
  assign iwe_b  = sel ? init_we : 1'b0;
  assign resp   = sel ? resp_b : resp_a;
  assign berr   = sel ? berr_b : berr_a;

  dbus_mem_responder #(.DEPTH(512), .LATENCY(2), .BASE(64'h8000_0000)) dut_a (
    .clk(clk), .reset(reset), .dreq(dreq_a), .dresp(resp_a), .bus_err(berr_a),
    .init_we(iwe_a), .init_idx(init_idx), .init_data(init_data)
  );

  dbus_mem_responder #(.DEPTH(512), .LATENCY(0), .BASE(64'h8000_0000)) dut_b (
    .clk(clk), .reset(reset), .dreq(dreq_b), .dresp(resp_b), .bus_err(berr_b),
    .init_we(iwe_b), .init_idx(init_idx), .init_data(init_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic backdoor(input logic [8:0] idx, input logic [63:0] val);
    init_we = 1'b1; init_idx = idx; init_data = val;
    @(posedge clk); #1;
    init_we = 1'b0;
  endtask

  // One bus transaction on the selected instance; hold keeps valid high through the RESP cycle.
  task automatic req_txn(input string tag, input logic [63:0] addr, input logic [1:0] size,
                         input logic [7:0] strb, input logic [63:0] wdat,
                         input logic [63:0] exp_data, input logic exp_err, input bit hold);
    int n;
    int lat;
    bit dup;
    lat = sel ? 0 : 2;
    dreq.valid = 1'b1; dreq.addr = addr; dreq.size = size; dreq.strobe = strb; dreq.data = wdat;
    #1;
    chk({tag, "_addr_ok"}, 64'(resp.addr_ok), 64'd1);
    @(posedge clk); #1;
    init_we = 1'b0;
    if (!hold) dreq.valid = 1'b0;
    n = 1;
    while (!resp.data_ok && n < 20) begin
      chk({tag, "_wait_addr_ok"}, 64'(resp.addr_ok), 64'd0);
      chk({tag, "_wait_data"}, resp.data, 64'd0);
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(lat + 1));
    chk({tag, "_data_ok"}, 64'(resp.data_ok), 64'd1);
    chk({tag, "_data"}, resp.data, exp_data);
    chk({tag, "_bus_err"}, 64'(berr), 64'(exp_err));
    chk({tag, "_resp_addr_ok"}, 64'(resp.addr_ok), 64'd0);
    @(posedge clk); #1;
    dreq.valid = 1'b0;
    #1;
    chk({tag, "_idle_data"}, resp.data, 64'd0);
    dup = 1'b0;
    for (int i = 0; i < lat + 2; i++) begin
      if (resp.data_ok || berr) dup = 1'b1;
      @(posedge clk); #1;
    end
    chk({tag, "_no_dup"}, 64'(dup), 64'd0);
  endtask

  initial begin
    sel = 1'b0;
    reset = 1'b0;
    dreq = '0;
    init_we = 1'b0; init_idx = '0; init_data = '0;
    #1;
    chk("rst_addr_ok", 64'(resp.addr_ok), 64'd0);
    chk("rst_data_ok", 64'(resp.data_ok), 64'd0);
    chk("rst_bus_err", 64'(berr), 64'd0);
    chk("rst_data", resp.data, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // LATENCY=2 instance
    backdoor(9'd0,   64'h0123_4567_89AB_CDEF);
    backdoor(9'd1,   64'h0);
    backdoor(9'd3,   64'hDEAD_BEEF_CAFE_F00D);
    backdoor(9'd511, 64'h5555_AAAA_1234_5678);

    req_txn("rd_w0", 64'h8000_0000, MSIZE8, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
    req_txn("wr_w1_lo", 64'h8000_0008, MSIZE8, 8'h0F, 64'hFFFF_FFFF_1111_2222, 64'h0, 1'b0, 1'b0);
    req_txn("rd_w1", 64'h8000_0008, MSIZE8, 8'h00, 64'h0, 64'h0000_0000_1111_2222, 1'b0, 1'b0);
    req_txn("wr_w1_hi", 64'h8000_0008, MSIZE8, 8'hF0, 64'hAAAA_BBBB_CCCC_DDDD,
            64'h0000_0000_1111_2222, 1'b0, 1'b0);
    req_txn("rd_w1b", 64'h8000_0008, MSIZE8, 8'h00, 64'h0, 64'hAAAA_BBBB_1111_2222, 1'b0, 1'b0);

    // Sub-word accesses and error cases
    req_txn("rd_sz4", 64'h8000_0004, MSIZE4, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
    req_txn("rd_sz1", 64'h8000_0007, MSIZE1, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
    req_txn("err_mis8", 64'h8000_0004, MSIZE8, 8'h00, 64'h0, 64'h0, 1'b1, 1'b0);
    req_txn("err_below", 64'h7FFF_FFF8, MSIZE8, 8'h00, 64'h0, 64'h0, 1'b1, 1'b0);
    req_txn("err_wr_mis2", 64'h8000_0001, MSIZE2, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    req_txn("rd_w0_kept", 64'h8000_0000, MSIZE8, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
    req_txn("rd_last", 64'h8000_0FF8, MSIZE8, 8'h00, 64'h0, 64'h5555_AAAA_1234_5678, 1'b0, 1'b0);
    req_txn("err_oob", 64'h8000_1000, MSIZE8, 8'h00, 64'h0, 64'h0, 1'b1, 1'b0);

    // Backdoor write and bus read of the same word in the same IDLE cycle
    init_we = 1'b1; init_idx = 9'd5; init_data = 64'h0BAD_F00D_1357_9BDF;
    req_txn("bd_same_cyc", 64'h8000_0028, MSIZE8, 8'h00, 64'h0, 64'h0BAD_F00D_1357_9BDF, 1'b0, 1'b0);

    // Valid held through RESP must not cause a second accept
    req_txn("hold_rd", 64'h8000_0018, MSIZE8, 8'h00, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1);

    // Reset in the middle of a write to word 3
    dreq.valid = 1'b1; dreq.addr = 64'h8000_0018; dreq.size = MSIZE8;
    dreq.strobe = 8'hFF; dreq.data = 64'h1111_1111_1111_1111;
    #1;
    chk("abort_addr_ok", 64'(resp.addr_ok), 64'd1);
    @(posedge clk); #1;
    dreq.valid = 1'b0;
    chk("abort_wait1", 64'(resp.data_ok), 64'd0);
    @(posedge clk); #1;
    chk("abort_wait2", 64'(resp.data_ok), 64'd0);
    reset = 1'b0;
    #1;
    chk("abort_rst_data_ok", 64'(resp.data_ok), 64'd0);
    chk("abort_rst_bus_err", 64'(berr), 64'd0);
    chk("abort_rst_data", resp.data, 64'd0);
    @(posedge clk); #1;
    chk("abort_rst_data_ok2", 64'(resp.data_ok), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    req_txn("abort_rd_w3", 64'h8000_0018, MSIZE8, 8'h00, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0);

    // LATENCY=0 instance: three chained table-walk style reads, valid held through data_ok
    sel = 1'b1;
    #1;
    backdoor(9'h10, 64'h0000_0000_8000_0100);
    backdoor(9'h20, 64'h0000_0000_8000_0200);
    backdoor(9'h40, 64'h0000_0000_00C0_FFEE);
    req_txn("walk_l2", 64'h8000_0080, MSIZE8, 8'h00, 64'h0, 64'h0000_0000_8000_0100, 1'b0, 1'b1);
    req_txn("walk_l1", 64'h8000_0100, MSIZE8, 8'h00, 64'h0, 64'h0000_0000_8000_0200, 1'b0, 1'b1);
    req_txn("walk_l0", 64'h8000_0200, MSIZE8, 8'h00, 64'h0, 64'h0000_0000_00C0_FFEE, 1'b0, 1'b1);
    req_txn("l0_err_mis4", 64'h8000_0202, MSIZE4, 8'h00, 64'h0, 64'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
